// File: rtl/turbo_qpp_interleaver_if.sv
// Stream bundle for the QPP interleaver: natural-order bit input and permuted-order bit output.
interface turbo_qpp_interleaver_if #(
  parameter int unsigned AW = 6
);
  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          out_valid;
  logic          out_bit;
  logic          out_ready;
  logic          out_last;
  logic [AW-1:0] out_addr;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_last, out_addr
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_last, out_addr
  );
endinterface

// File: rtl/turbo_qpp_interleaver.sv
// Single-buffer QPP interleaver: fills K bits in natural order, drains them at pi(i)=(F1*i+F2*i^2) mod K.
module turbo_qpp_interleaver #(
  parameter int unsigned K  = 40,
  parameter int unsigned F1 = 3,
  parameter int unsigned F2 = 10,
  parameter int unsigned AW = 6
) (
  input logic                  clk,
  input logic                  clr,
  turbo_qpp_interleaver_if.slave bus
);

  typedef enum logic { S_FILL, S_DRAIN } state_t;

  localparam logic [AW:0]   K_X = (AW+1)'(K);
  localparam logic [AW-1:0] KM1 = AW'(K - 1);
  localparam logic [AW-1:0] G0  = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] D2  = AW'((2 * F2) % K);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] pi_q, pi_d;
  logic [AW-1:0] g_q, g_d;
  logic [K-1:0]  mem_q, mem_d;

  logic in_ready, out_valid, out_bit, out_last;

  // Both operands are already < K, so one conditional subtract reduces the sum.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= K_X) s = s - K_X;
    return s[AW-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    pi_d      = pi_q;
    g_d       = g_q;
    mem_d     = mem_q;
    in_ready  = (state_q == S_FILL);
    out_valid = (state_q == S_DRAIN);
    out_bit   = out_valid & mem_q[pi_q];
    out_last  = out_valid && (rd_q == KM1);
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          mem_d[wr_q] = bus.in_bit;
          if (wr_q == KM1) begin
            wr_d    = '0;
            state_d = S_DRAIN;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (rd_q == KM1) begin
            state_d = S_FILL;
            rd_d    = '0;
            pi_d    = '0;
            g_d     = G0;
          end else begin
            rd_d = rd_q + 1'b1;
            pi_d = mod_add(pi_q, g_q);
            g_d  = mod_add(g_q, D2);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_FILL;
      wr_q    <= '0;
      rd_q    <= '0;
      pi_q    <= '0;
      g_q     <= G0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
    end
  end

  // Block storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;
  assign bus.out_last  = out_last;
  assign bus.out_addr  = pi_q;

endmodule

// File: tb/tb_turbo_qpp_interleaver.sv
// Self-checking bench for turbo_qpp_interleaver (K=40, F1=3, F2=10) against a direct-formula model.
module tb_turbo_qpp_interleaver;

  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
  localparam int AW = 6;

  logic clk;
  logic clr;

  turbo_qpp_interleaver_if #(.AW(AW)) bus ();

  turbo_qpp_interleaver #(.K(K), .F1(F1), .F2(F2), .AW(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qpp(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  // Behavioural model: phase, counters and stored block
  bit m_fill = 1'b1;
  int m_wr   = 0;
  int m_rd   = 0;
  bit m_mem [K];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_fill <= 1'b1;
      m_wr   <= 0;
      m_rd   <= 0;
    end else if (m_fill) begin
      if (bus.in_valid) begin
        m_mem[m_wr] <= bus.in_bit;
        if (m_wr == K - 1) begin
          m_wr   <= 0;
          m_fill <= 1'b0;
        end else begin
          m_wr <= m_wr + 1;
        end
      end
    end else if (bus.out_ready) begin
      if (m_rd == K - 1) begin
        m_rd   <= 0;
        m_fill <= 1'b1;
      end else begin
        m_rd <= m_rd + 1;
      end
    end
  end

  int cap_addr [K];
  int cap_bit  [K];
  int cap_last [K];

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(bus.in_ready),  int'(m_fill));
      check("out_valid", int'(bus.out_valid), int'(!m_fill));
      check("out_addr",  int'(bus.out_addr),  m_fill ? 0 : qpp(m_rd));
      check("out_bit",   int'(bus.out_bit),   m_fill ? 0 : int'(m_mem[qpp(m_rd)]));
      check("out_last",  int'(bus.out_last),  (!m_fill && m_rd == K - 1) ? 1 : 0);
      if (!m_fill && bus.out_ready) begin
        cap_addr[m_rd] = int'(bus.out_addr);
        cap_bit[m_rd]  = int'(bus.out_bit);
        cap_last[m_rd] = int'(bus.out_last);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed_block(input logic [K-1:0] b);
    for (int i = 0; i < K; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = b[i];
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic check_perm(input string name);
    int seen [K];
    for (int i = 0; i < K; i++) seen[i] = 0;
    for (int i = 0; i < K; i++) seen[cap_addr[i] % K]++;
    for (int i = 0; i < K; i++) check(name, seen[i], 1);
  endtask

  task automatic check_ref(input string name, input logic [K-1:0] b);
    for (int i = 0; i < K; i++) check(name, cap_bit[i], int'(b[qpp(i)]));
  endtask

  function automatic int count_ones();
    int c = 0;
    for (int i = 0; i < K; i++) c += cap_bit[i];
    return c;
  endfunction

  logic [K-1:0] blk, blk_b;
  int held_addr, held_bit, held_last;

  initial begin
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    step(2);
    chk_en = 1'b1;

    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_bit",   int'(bus.out_bit), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    check("rst_out_addr",  int'(bus.out_addr), 0);
    clr = 1'b1;
    step(1);

    // Single one at index 13
    bus.out_ready = 1'b1;
    blk = '0;
    blk[13] = 1'b1;
    feed_block(blk);
    check("first_valid_latency", int'(bus.out_valid), 1);
    step(K);
    check("addr0", cap_addr[0], 0);
    check("addr1", cap_addr[1], 13);
    check("addr2", cap_addr[2], 6);
    check("addr3", cap_addr[3], 19);
    check("one_at_pos1", cap_bit[1], 1);
    check("ones_cnt13", count_ones(), 1);
    check_perm("perm_cover");
    check_ref("ref13", blk);

    // Single one at index 7 lands on the last position
    blk = '0;
    blk[7] = 1'b1;
    feed_block(blk);
    step(K);
    check("one_at_pos39", cap_bit[K-1], 1);
    check("last_at_pos39", cap_last[K-1], 1);
    check("addr_pos39", cap_addr[K-1], 7);
    check("last_at_pos38", cap_last[K-2], 0);
    check("ones_cnt7", count_ones(), 1);

    // Backpressure at position 10 with stray in_valid pulses
    blk = {$urandom, $urandom};
    feed_block(blk);
    step(10);
    bus.out_ready = 1'b0;
    held_addr = int'(bus.out_addr);
    held_bit  = int'(bus.out_bit);
    held_last = int'(bus.out_last);
    check("stall_addr_pos10", held_addr, qpp(10));
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      bus.in_bit   = 1'b1;
      step(1);
      check("stall_addr", int'(bus.out_addr), held_addr);
      check("stall_bit",  int'(bus.out_bit),  held_bit);
      check("stall_last", int'(bus.out_last), held_last);
      check("stall_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    step(K - 10);
    check_perm("perm_bp");
    check_ref("ref_bp", blk);

    // Back-to-back blocks with in_valid held high throughout
    blk   = {$urandom, $urandom};
    blk_b = {$urandom, $urandom};
    for (int c = 0; c < 3 * K; c++) begin
      if (c == 2 * K - 1) check("b2b_in_ready_pos39", int'(bus.in_ready), 0);
      if (c == 2 * K) begin
        check("b2b_in_ready_after", int'(bus.in_ready), 1);
        check_ref("ref_b2b_a", blk);
      end
      bus.in_valid = 1'b1;
      if (c < K)          bus.in_bit = blk[c];
      else if (c < 2 * K) bus.in_bit = 1'($urandom);
      else                bus.in_bit = blk_b[c - 2 * K];
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    check("b2b_b_addr0", int'(bus.out_addr), 0);
    step(K);
    check_ref("ref_b2b_b", blk_b);
    check_perm("perm_b2b");

    // Reset pulse at drain position 20
    blk = {$urandom, $urandom};
    feed_block(blk);
    step(20);
    check("pre_rst_addr", int'(bus.out_addr), qpp(20));
    clr = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready",  int'(bus.in_ready), 1);
    check("midrst_out_addr",  int'(bus.out_addr), 0);
    step(1);
    clr = 1'b1;
    step(1);
    blk = {$urandom, $urandom};
    feed_block(blk);
    step(K);
    check_ref("ref_after_rst", blk);
    check_perm("perm_after_rst");

    step(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/turbo_qpp_interleaver.md
Name: turbo_qpp_interleaver

Overview:
- Bit-level QPP interleaver that sits directly upstream of the second constituent encoder in the turbo encoder.
- Buffers one block of K systematic bits in natural order, then replays them in permuted order pi(i) = (F1*i + F2*i^2) mod K.
- The permuted stream drives the second encoder's u/enable, which produces Zprimek.
- Single buffer: the block alternates between a FILL phase and a DRAIN phase.

Parameters:
- K, 40: block length in bits; legal range 2..6144.
- F1, 3: QPP linear coefficient; must satisfy 0 <= F1 < K.
- F2, 10: QPP quadratic coefficient; must satisfy 0 <= F2 < K.
- AW, 6: index width; must satisfy 2^AW >= K.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is valid.
- in_bit  in  1  systematic bit, natural order.
- in_ready  out  1  block can accept a bit.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  permuted bit (feeds encoder u).
- out_ready  in  1  downstream consumes the bit this cycle (encoder enable).
- out_last  out  1  marks output position K-1.
- out_addr  out  AW  current pi(i), for verification.

Behaviour:
- **Reset** (clr=0, asynchronous):
  - state=FILL; write counter wr=0; read counter rd=0.
  - pi=0; g=(F1+F2) mod K.
  - Outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0, out_addr=0.
  - Buffer contents are not reset.
- **FILL state:**
  - in_ready=1, out_valid=0.
  - On in_valid=1, store in_bit at mem[wr] and increment wr.
  - On the accept with wr=K-1: wr wraps to 0 and state moves to DRAIN on the next cycle.
  - out_ready is ignored in FILL.
- **DRAIN state:**
  - in_ready=0; in_valid is ignored and no write occurs.
  - out_valid=1, out_bit=mem[pi], out_addr=pi.
  - out_bit is a combinational read of the flop array and is gated to 0 when out_valid=0.
- **Permutation recursion** (no multipliers):
  - pi(0)=0; g(0)=(F1+F2) mod K.
  - On each handshake (out_valid & out_ready): pi <= (pi+g) mod K, g <= (g + (2*F2 mod K)) mod K, rd <= rd+1.
  - Every modular add has both operands < K: compute the sum at AW+1 bits and subtract K if sum >= K.
  - 2*F2 mod K is an elaboration-time constant.
- **out_last** = 1 when in DRAIN and rd=K-1.
- **End of drain:** a handshake with rd=K-1 returns state to FILL and restores rd=0, pi=0, g=(F1+F2) mod K.
  - in_ready is asserted the next cycle.
- **Backpressure:** while out_ready=0, out_bit, out_addr, out_last, pi, g and rd all hold.
- **Latency:**
  - The first output bit is valid in the cycle after the K-th input accept.
  - Throughput is 1 bit/cycle in each phase; total 2K cycles per block with no stalls.
- **Mid-operation reset:** clr low in either state aborts the block immediately. After release the block is in FILL with wr=0; the partial block is discarded.
- **Permutation validity:** correct permutation is guaranteed only for (K,F1,F2) forming a valid QPP (e.g. the LTE table). Invalid triples still produce indices < K, but not a permutation.

Test Plan:
- **Single-one pattern:** reset; K=40, F1=3, F2=10; feed 40 bits with only index 13 = 1, out_ready=1.
  - First out_valid one cycle after the last accept.
  - out_addr sequence starts 0, 13, 6, 19.
  - out_bit=1 only at output position 1.
- **Last position:** input with only index 7 = 1.
  - out_bit=1 only at output position 39, coincident with out_last=1 and out_addr=7.
- **Full-permutation coverage:** record all 40 out_addr values.
  - Each of 0..39 appears exactly once.
  - Output equals a reference model of in[(3i+10i^2) mod 40].
- **Backpressure:** deassert out_ready for 5 cycles at output position 10.
  - out_bit, out_addr and out_last are stable; positions 10..39 are still delivered in order.
  - in_ready stays 0 and in_valid pulses during DRAIN are not written.
- **Back-to-back blocks:** two random blocks with in_valid held high.
  - in_ready returns 1 the cycle after the position-39 handshake.
  - The second block's permuted output is correct and out_addr restarts at 0.
- **Reset mid-drain:** pulse clr low at output position 20.
  - Next cycle: out_valid=0, in_ready=1, out_addr=0.
  - A fresh block then permutes correctly.
